axi_reg_slice: RTL and testbench

Fully registered AXI4 pipeline stage (64-bit data, 8-bit ID, 32-bit address) that sits directly downstream of the address-remapping stage on the FPGA memory path and feeds the PS HP/DDR port. It breaks every combinational path through the remapper on all five channels with a two-entry skid buffer per channel. Throughput is one beat per cycle. An optional limiter caps outstanding read and write transactions.

---
 rtl/axi_reg_slice.sv | 240 ++++++++++++++++++++++++
 tb/tb_axi_reg_slice.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_reg_slice.sv
// Fully registered AXI4 pipeline stage with a two-entry skid buffer on AW, W, B, AR and R.
// Define AXI_REG_SLICE_OUTSTANDING_LIMIT_EN to cap in-flight reads and writes at MAX_OUTSTANDING.

module axi_reg_slice_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             ready_q, in_hs, out_hs;
  logic             load_main_in, load_main_skid, load_skid;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign in_ready  = ready_q;
  assign in_hs     = in_valid & ready_q;
  assign out_hs    = (state != EMPTY) & out_ready;

  // Ready is registered from the next state so it never depends on out_ready combinationally
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next != FULL);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (in_hs) state_next = ONE;
      ONE: begin
        if (in_hs && !out_hs)      state_next = FULL;
        else if (!in_hs && out_hs) state_next = EMPTY;
      end
      FULL:    if (out_hs) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: load_main_in = in_hs;
      ONE: begin
        load_main_in = in_hs & out_hs;
        load_skid    = in_hs & ~out_hs;
      end
      FULL:    load_main_skid = out_hs;
      default: ;
    endcase
  end
endmodule

module axi_reg_slice #(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  s_axi_awid,
  input  logic [31:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic        s_axi_awlock,
  input  logic [3:0]  s_axi_awcache,
  input  logic [2:0]  s_axi_awprot,
  input  logic [3:0]  s_axi_awqos,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [7:0]  s_axi_bid,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [7:0]  s_axi_arid,
  input  logic [31:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  input  logic        s_axi_arlock,
  input  logic [3:0]  s_axi_arcache,
  input  logic [2:0]  s_axi_arprot,
  input  logic [3:0]  s_axi_arqos,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [7:0]  s_axi_rid,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [7:0]  m_axi_awid,
  output logic [31:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic        m_axi_awlock,
  output logic [3:0]  m_axi_awcache,
  output logic [2:0]  m_axi_awprot,
  output logic [3:0]  m_axi_awqos,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [63:0] m_axi_wdata,
  output logic [7:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [7:0]  m_axi_bid,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [7:0]  m_axi_arid,
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic        m_axi_arlock,
  output logic [3:0]  m_axi_arcache,
  output logic [2:0]  m_axi_arprot,
  output logic [3:0]  m_axi_arqos,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [7:0]  m_axi_rid,
  input  logic [63:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 255) begin : g_bad_max
    $error("axi_reg_slice: MAX_OUTSTANDING must be within 1..255");
  end

  logic [64:0] aw_in, aw_out, ar_in, ar_out;
  logic [72:0] w_in, w_out;
  logic [9:0]  b_in, b_out;
  logic [74:0] r_in, r_out;
  logic        aw_allow, ar_allow, aw_slice_ready, ar_slice_ready;

  assign aw_in = {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
                  s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos};
  assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
          m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos} = aw_out;
  assign ar_in = {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
                  s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};
  assign {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
          m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos} = ar_out;
  assign w_in  = {s_axi_wdata, s_axi_wstrb, s_axi_wlast};
  assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast} = w_out;
  assign b_in  = {m_axi_bid, m_axi_bresp};
  assign {s_axi_bid, s_axi_bresp} = b_out;
  assign r_in  = {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast};
  assign {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} = r_out;

  assign s_axi_awready = aw_slice_ready & aw_allow;
  assign s_axi_arready = ar_slice_ready & ar_allow;

`ifdef AXI_REG_SLICE_OUTSTANDING_LIMIT_EN
  logic [7:0] rd_cnt, wr_cnt;
  logic       rd_inc, rd_dec, wr_inc, wr_dec;

  assign rd_inc   = s_axi_arvalid & s_axi_arready;
  assign rd_dec   = s_axi_rvalid & s_axi_rready & s_axi_rlast;
  assign wr_inc   = s_axi_awvalid & s_axi_awready;
  assign wr_dec   = s_axi_bvalid & s_axi_bready;
  assign ar_allow = (rd_cnt < 8'(MAX_OUTSTANDING));
  assign aw_allow = (wr_cnt < 8'(MAX_OUTSTANDING));

  // A decrement at zero is a protocol error; the counter holds rather than wrapping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_cnt <= 8'd0;
      wr_cnt <= 8'd0;
    end else begin
      case ({rd_inc, rd_dec})
        2'b10:   rd_cnt <= rd_cnt + 8'd1;
        2'b01:   if (rd_cnt != 8'd0) rd_cnt <= rd_cnt - 8'd1;
        default: ;
      endcase
      case ({wr_inc, wr_dec})
        2'b10:   wr_cnt <= wr_cnt + 8'd1;
        2'b01:   if (wr_cnt != 8'd0) wr_cnt <= wr_cnt - 8'd1;
        default: ;
      endcase
    end
  end

  rd_no_underflow: assert property (@(posedge clock) disable iff (reset) rd_dec |-> rd_cnt != 8'd0);
  wr_no_underflow: assert property (@(posedge clock) disable iff (reset) wr_dec |-> wr_cnt != 8'd0);
`else
  assign ar_allow = 1'b1;
  assign aw_allow = 1'b1;
`endif

  axi_reg_slice_stage #(.WIDTH(65)) u_aw (
    .clock(clock), .reset(reset), .in_valid(s_axi_awvalid & aw_allow), .in_ready(aw_slice_ready),
    .in_data(aw_in), .out_valid(m_axi_awvalid), .out_ready(m_axi_awready), .out_data(aw_out));
  axi_reg_slice_stage #(.WIDTH(73)) u_w (
    .clock(clock), .reset(reset), .in_valid(s_axi_wvalid), .in_ready(s_axi_wready),
    .in_data(w_in), .out_valid(m_axi_wvalid), .out_ready(m_axi_wready), .out_data(w_out));
  axi_reg_slice_stage #(.WIDTH(10)) u_b (
    .clock(clock), .reset(reset), .in_valid(m_axi_bvalid), .in_ready(m_axi_bready),
    .in_data(b_in), .out_valid(s_axi_bvalid), .out_ready(s_axi_bready), .out_data(b_out));
  axi_reg_slice_stage #(.WIDTH(65)) u_ar (
    .clock(clock), .reset(reset), .in_valid(s_axi_arvalid & ar_allow), .in_ready(ar_slice_ready),
    .in_data(ar_in), .out_valid(m_axi_arvalid), .out_ready(m_axi_arready), .out_data(ar_out));
  axi_reg_slice_stage #(.WIDTH(75)) u_r (
    .clock(clock), .reset(reset), .in_valid(m_axi_rvalid), .in_ready(m_axi_rready),
    .in_data(r_in), .out_valid(s_axi_rvalid), .out_ready(s_axi_rready), .out_data(r_out));
endmodule

// File: tb/tb_axi_reg_slice.sv
// Scoreboard bench for axi_reg_slice: beats are queued on acceptance and checked on delivery.
// Limiter checks compile only with AXI_REG_SLICE_OUTSTANDING_LIMIT_EN defined.

module tb_axi_reg_slice;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  s_axi_awid, s_axi_awlen, s_axi_arid, s_axi_arlen, m_axi_bid, m_axi_rid;
  logic [31:0] s_axi_awaddr, s_axi_araddr;
  logic [2:0]  s_axi_awsize, s_axi_awprot, s_axi_arsize, s_axi_arprot;
  logic [1:0]  s_axi_awburst, s_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic [3:0]  s_axi_awcache, s_axi_awqos, s_axi_arcache, s_axi_arqos;
  logic        s_axi_awlock, s_axi_arlock, s_axi_awvalid, s_axi_arvalid, s_axi_wvalid, s_axi_wlast;
  logic [63:0] s_axi_wdata, m_axi_rdata;
  logic [7:0]  s_axi_wstrb;
  logic        s_axi_bready, s_axi_rready, m_axi_awready, m_axi_wready, m_axi_arready;
  logic        m_axi_bvalid, m_axi_rvalid, m_axi_rlast;
  logic        s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast;
  logic [7:0]  s_axi_bid, s_axi_rid, m_axi_awid, m_axi_awlen, m_axi_arid, m_axi_arlen, m_axi_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp, m_axi_awburst, m_axi_arburst;
  logic [63:0] s_axi_rdata, m_axi_wdata;
  logic [31:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]  m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
  logic [3:0]  m_axi_awcache, m_axi_awqos, m_axi_arcache, m_axi_arqos;
  logic        m_axi_awlock, m_axi_arlock, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_arvalid;
  logic        m_axi_bready, m_axi_rready;

  logic [74:0] aw_q[$], w_q[$], b_q[$], ar_q[$], r_q[$];
  int checks = 0, passes = 0, w_pops = 0, r_pops = 0;

  axi_reg_slice #(.MAX_OUTSTANDING(2)) dut (
    .clock(clock), .reset(reset),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready));

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic report_extra(input string name);
    checks++;
    $display("[TB] FAIL %s: got an output beat, expected none pending", name);
  endtask

  // Beats are queued when the source side accepts them and popped when the sink side takes them
  always @(negedge clock) begin
    if (reset) begin
      aw_q.delete(); w_q.delete(); b_q.delete(); ar_q.delete(); r_q.delete();
    end else begin
      if (m_axi_awvalid && m_axi_awready) begin
        if (aw_q.size() == 0) report_extra("aw_extra");
        else check_output("aw_beat", {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
                          m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos}, aw_q.pop_front());
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_pops++;
        if (w_q.size() == 0) report_extra("w_extra");
        else check_output("w_beat", {m_axi_wdata, m_axi_wstrb, m_axi_wlast}, w_q.pop_front());
      end
      if (m_axi_arvalid && m_axi_arready) begin
        if (ar_q.size() == 0) report_extra("ar_extra");
        else check_output("ar_beat", {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
                          m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos}, ar_q.pop_front());
      end
      if (s_axi_bvalid && s_axi_bready) begin
        if (b_q.size() == 0) report_extra("b_extra");
        else check_output("b_beat", {s_axi_bid, s_axi_bresp}, b_q.pop_front());
      end
      if (s_axi_rvalid && s_axi_rready) begin
        r_pops++;
        if (r_q.size() == 0) report_extra("r_extra");
        else check_output("r_beat", {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}, r_q.pop_front());
      end
      if (s_axi_awvalid && s_axi_awready)
        aw_q.push_back(75'({s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
                            s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos}));
      if (s_axi_wvalid && s_axi_wready) w_q.push_back(75'({s_axi_wdata, s_axi_wstrb, s_axi_wlast}));
      if (s_axi_arvalid && s_axi_arready)
        ar_q.push_back(75'({s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
                            s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos}));
      if (m_axi_bvalid && m_axi_bready) b_q.push_back(75'({m_axi_bid, m_axi_bresp}));
      if (m_axi_rvalid && m_axi_rready) r_q.push_back({m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast});
    end
  end

  task automatic apply_stimulus_idle();
    {s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, m_axi_bvalid, m_axi_rvalid} = '0;
    {m_axi_awready, m_axi_wready, m_axi_arready, s_axi_bready, s_axi_rready} = '1;
    {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
     s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos} = '0;
    {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
     s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos} = '0;
    {s_axi_wdata, s_axi_wstrb, s_axi_wlast} = '0;
    {m_axi_bid, m_axi_bresp} = '0;
    {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast} = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    apply_stimulus_idle();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
  endtask

  function automatic logic [9:0] hs_outputs();
    return {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, s_axi_bvalid, s_axi_rvalid,
            s_axi_awready, s_axi_wready, s_axi_arready, m_axi_bready, m_axi_rready};
  endfunction

  initial begin
    int w_base, r_base, wv_cnt, ar_acc, aw_acc, rl_sent, b_sent;
    logic fire, done, aw_f, w_f, ar_f, b_f, r_f;
    logic [95:0] rnd;

    apply_stimulus_idle();
    repeat (2) @(posedge clock);
    #1;
    check_output("reset_handshakes", hs_outputs(), 10'd0);
    check_output("reset_payload", {m_axi_araddr, m_axi_wdata, s_axi_rdata}, 160'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    check_output("readies_after_reset", {s_axi_awready, s_axi_wready, s_axi_arready, m_axi_bready, m_axi_rready}, 5'b11111);

    // Single AR: visible on the master side exactly one cycle after acceptance
    s_axi_arvalid = 1'b1; s_axi_arid = 8'h21; s_axi_araddr = 32'h1000_0040; s_axi_arlen = 8'd3;
    s_axi_arsize = 3'd3; s_axi_arburst = 2'b01; s_axi_arcache = 4'h3;
    check_output("ar_not_early", m_axi_arvalid, 1'b0);
    @(posedge clock); #1;
    s_axi_arvalid = 1'b0;
    check_output("ar_latency", m_axi_arvalid, 1'b1);
    check_output("ar_addr", m_axi_araddr, 32'h1000_0040);
    check_output("ar_len_id", {m_axi_arlen, m_axi_arid}, 16'h0321);
    @(posedge clock); #1;
    check_output("ar_single_beat", m_axi_arvalid, 1'b0);

    // 16-beat W stream with the sink always ready must flow with no bubbles
    w_base = w_pops; wv_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = 64'(i); s_axi_wstrb = 8'hFF; s_axi_wlast = (i == 15);
      @(posedge clock); #1;
      wv_cnt += int'(m_axi_wvalid);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    @(posedge clock); #1;
    check_output("w_no_bubbles", wv_cnt, 16);
    check_output("w_stream_count", w_pops - w_base, 16);

    // R stall: only two beats absorbed while the slave side is not ready
    r_base = r_pops; s_axi_rready = 1'b0; m_axi_rvalid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_axi_rid = 8'h5A; m_axi_rdata = 64'h0123_4567_89AB_CDE0 + 64'(k); m_axi_rresp = 2'(k); m_axi_rlast = 1'b0;
      @(posedge clock); #1;
    end
    m_axi_rdata = 64'h0123_4567_89AB_CDE2; m_axi_rresp = 2'd2; m_axi_rlast = 1'b1;
    check_output("r_stall_ready", m_axi_rready, 1'b0);
    check_output("r_stall_head", {s_axi_rvalid, s_axi_rdata}, {1'b1, 64'h0123_4567_89AB_CDE0});
    repeat (3) @(posedge clock); #1;
    check_output("r_stall_hold", {m_axi_rready, s_axi_rdata}, {1'b0, 64'h0123_4567_89AB_CDE0});
    s_axi_rready = 1'b1; done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clock); fire = m_axi_rready;
      @(posedge clock); #1; done = fire;
    end
    check_output("r_third_accepted", done, 1'b1);
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    repeat (4) @(posedge clock); #1;
    check_output("r_stall_count", r_pops - r_base, 3);

    // Reset in the middle of an 8-beat W burst clears everything at once
    for (int i = 0; i < 5; i++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = 64'hB0 + 64'(i); s_axi_wlast = 1'b0;
      @(posedge clock); #1;
    end
    reset = 1'b1; s_axi_wvalid = 1'b0;
    #1;
    check_output("reset_mid_handshakes", hs_outputs(), 10'd0);
    check_output("reset_mid_payload", m_axi_wdata, 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    w_base = w_pops;
    s_axi_wvalid = 1'b1; s_axi_wdata = 64'h00C0_FFEE; s_axi_wlast = 1'b1;
    @(posedge clock); #1;
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    check_output("w_after_reset_valid", {m_axi_wvalid, m_axi_wdata}, {1'b1, 64'h00C0_FFEE});
    @(posedge clock); #1;
    check_output("w_after_reset_count", w_pops - w_base, 1);

`ifdef AXI_REG_SLICE_OUTSTANDING_LIMIT_EN
    // Limit of two: the third AR waits until a read burst completes
    for (int i = 0; i < 2; i++) begin
      s_axi_arvalid = 1'b1; s_axi_araddr = 32'h2000_0000 + 32'(i * 64);
      @(posedge clock); #1;
    end
    s_axi_araddr = 32'h2000_0080;
    check_output("ar_limit_held", s_axi_arready, 1'b0);
    repeat (2) @(posedge clock); #1;
    check_output("ar_limit_still_held", s_axi_arready, 1'b0);
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rdata = 64'h77;
    @(posedge clock); #1;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    check_output("ar_limit_until_rlast", s_axi_arready, 1'b0);
    @(posedge clock); #1;
    check_output("ar_limit_released", s_axi_arready, 1'b1);
    @(posedge clock); #1;
    s_axi_arvalid = 1'b0;
    check_output("ar_third_forwarded", {m_axi_arvalid, m_axi_araddr}, {1'b1, 32'h2000_0080});
`endif

    // Random valid/ready toggling; responses never outnumber accepted requests
    apply_reset();
    ar_acc = 0; aw_acc = 0; rl_sent = 0; b_sent = 0; w_base = w_pops; r_base = r_pops;
    repeat (10000) begin
      @(negedge clock);
      aw_f = s_axi_awvalid & s_axi_awready; w_f = s_axi_wvalid & s_axi_wready;
      ar_f = s_axi_arvalid & s_axi_arready; b_f = m_axi_bvalid & m_axi_bready;
      r_f  = m_axi_rvalid & m_axi_rready;
      if (aw_f) aw_acc++;
      if (ar_f) ar_acc++;
      if (b_f) b_sent++;
      if (r_f && m_axi_rlast) rl_sent++;
      @(posedge clock); #1;
      if (!s_axi_awvalid || aw_f) begin
        rnd = {$urandom, $urandom, $urandom}; s_axi_awvalid = rnd[95];
        {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
         s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos} = rnd[64:0];
      end
      if (!s_axi_wvalid || w_f) begin
        rnd = {$urandom, $urandom, $urandom}; s_axi_wvalid = rnd[95];
        {s_axi_wdata, s_axi_wstrb, s_axi_wlast} = rnd[72:0];
      end
      if (!s_axi_arvalid || ar_f) begin
        rnd = {$urandom, $urandom, $urandom}; s_axi_arvalid = rnd[95];
        {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
         s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos} = rnd[64:0];
      end
      if (!m_axi_bvalid || b_f) begin
        rnd = {$urandom, $urandom, $urandom};
        m_axi_bvalid = rnd[95] && (b_sent < aw_acc);
        {m_axi_bid, m_axi_bresp} = rnd[9:0];
      end
      if (!m_axi_rvalid || r_f) begin
        rnd = {$urandom, $urandom, $urandom}; m_axi_rvalid = rnd[95];
        {m_axi_rid, m_axi_rdata, m_axi_rresp} = rnd[73:0];
        m_axi_rlast = rnd[94] && (rl_sent < ar_acc);
      end
      rnd = 96'($urandom);
      {m_axi_awready, m_axi_wready, m_axi_arready, s_axi_bready, s_axi_rready} = rnd[4:0];
    end
    apply_stimulus_idle();
    repeat (10) @(posedge clock); #1;
    check_output("random_traffic", (w_pops > w_base) && (r_pops > r_base), 1'b1);
    check_output("aw_drained", aw_q.size(), 0);
    check_output("w_drained", w_q.size(), 0);
    check_output("ar_drained", ar_q.size(), 0);
    check_output("b_drained", b_q.size(), 0);
    check_output("r_drained", r_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
